// File: rtl/matrix_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_op_sequencer_if
// Description : Request/response bundle for the sequenced 2x2 matrix engine.
//               The master drives start/op/operands; the slave returns
//               busy/done/err and the packed result.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_op_sequencer_if #(
    parameter int EW = 3,
    parameter int RW = 2 * EW + 1
);
    logic              start;
    logic [1:0]        op;
    logic [4*EW-1:0]   a;
    logic [4*EW-1:0]   b;
    logic              busy;
    logic              done;
    logic              err;
    logic [4*RW-1:0]   c;

    modport master (output start, op, a, b, input busy, done, err, c);
    modport slave  (input start, op, a, b, output busy, done, err, c);
endinterface
`default_nettype wire

// File: rtl/matrix_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_op_sequencer
// Description : Time-shared 2x2 matrix add / subtract / multiply engine.
//               One multiplier and one adder/subtractor are walked over the
//               four result elements; the result is published on entry to
//               FIN together with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_op_sequencer #(
    parameter int EW = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_op_sequencer_if.slave  bus
);
    localparam int RW = 2 * EW + 1;

    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_MUL = 2'b10;
    localparam logic [1:0] C_OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_last;

    logic [1:0]        r_op;
    logic [4*EW-1:0]   r_a;
    logic [4*EW-1:0]   r_b;
    logic [2:0]        r_step;
    logic [RW-1:0]     r_acc;
    logic [4*RW-1:0]   r_shadow;
    logic [4*RW-1:0]   r_c;

    logic              w_is_mul;
    logic [1:0]        w_idx;
    logic              w_phase;
    logic [EW-1:0]     w_mul_x;
    logic [EW-1:0]     w_mul_y;
    logic [RW-1:0]     w_prod;
    logic [RW-1:0]     w_add_x;
    logic [RW-1:0]     w_add_y;
    logic              w_subtract;
    logic [RW-1:0]     w_sum;
    logic              w_wr;
    logic [4*RW-1:0]   w_shadow_next;

    // Element k of a packed matrix, k = 2*row + col, element 0 in the MSBs.
    function automatic logic [EW-1:0] elem(input logic [4*EW-1:0] m, input logic [1:0] k);
        return m[(3 - int'(k))*EW +: EW];
    endfunction

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = w_is_mul ? (r_step == 3'd7) : (r_step == 3'd3);
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = (bus.op == C_OP_ILL) ? FIN : EXEC;
                end
            end
            EXEC:    if (w_last) w_state_next = FIN;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Shared datapath: multiply uses two steps per element (row-col dot
    // product), add/sub one step per element.
    always_comb begin
        w_is_mul   = (r_op == C_OP_MUL);
        w_idx      = w_is_mul ? r_step[2:1] : r_step[1:0];
        w_phase    = r_step[0];
        w_mul_x    = elem(r_a, {w_idx[1], w_phase});
        w_mul_y    = elem(r_b, {w_phase, w_idx[0]});
        w_prod     = RW'(w_mul_x) * RW'(w_mul_y);
        w_subtract = 1'b0;
        if (w_is_mul) begin
            w_add_x = r_acc;
            w_add_y = w_prod;
        end else begin
            w_add_x    = RW'(elem(r_a, w_idx));
            w_add_y    = RW'(elem(r_b, w_idx));
            w_subtract = (r_op == C_OP_SUB);
        end
        // RW-bit wraparound of the zero-extended difference is exactly the
        // sign-extended two's complement result.
        w_sum = w_subtract ? (w_add_x - w_add_y) : (w_add_x + w_add_y);
        w_wr  = (r_state == EXEC) && (!w_is_mul || w_phase);
        w_shadow_next = r_shadow;
        if (w_wr) begin
            w_shadow_next[(3 - int'(w_idx))*RW +: RW] = w_sum;
        end
    end

    // Operand latches, step counter, accumulator, shadow and published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_step   <= '0;
            r_acc    <= '0;
            r_shadow <= '0;
            r_c      <= '0;
        end else if (w_accept) begin
            r_op   <= bus.op;
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_step <= '0;
            r_acc  <= '0;
            if (bus.op == C_OP_ILL) begin
                r_c <= '0;
            end
        end else if (r_state == EXEC) begin
            r_step   <= r_step + 3'd1;
            r_shadow <= w_shadow_next;
            if (w_is_mul && !w_phase) begin
                r_acc <= w_prod;
            end
            // The final element lands in the same edge that enters FIN, so
            // publish the shadow including that write.
            if (w_last) begin
                r_c <= w_shadow_next;
            end
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == FIN);
    assign bus.err  = (r_state == FIN) && (r_op == C_OP_ILL);
    assign bus.c    = r_c;

endmodule
`default_nettype wire

// File: tb/tb_matrix_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_op_sequencer
// Description : Self-checking bench for matrix_op_sequencer: table vectors,
//               scoreboard of expected results, and hand-written sequences
//               for start toggling, mid-operation reset and back-to-back ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_op_sequencer;
    localparam int EW = 3;
    localparam int RW = 2 * EW + 1;

    typedef struct {
        logic [1:0]      op;
        logic [4*EW-1:0] a;
        logic [4*EW-1:0] b;
        logic [4*RW-1:0] c;
        logic            err;
        int              lat;
    } vec_t;

    typedef struct {
        logic [4*RW-1:0] c;
        logic            err;
        int              lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;
    logic [4*RW-1:0] prev_c;
    exp_t sb[$];
    vec_t vt[8];

    matrix_op_sequencer_if #(.EW(EW)) bus ();

    matrix_op_sequencer #(.EW(EW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*EW-1:0] pa(input logic [EW-1:0] x0, x1, x2, x3);
        return {x0, x1, x2, x3};
    endfunction

    function automatic logic [4*RW-1:0] pc(input logic [RW-1:0] x0, x1, x2, x3);
        return {x0, x1, x2, x3};
    endfunction

    // Plain 2x2 matrix arithmetic, element (i,j) at index 2*i+j.
    function automatic logic [4*RW-1:0] model(input logic [1:0] op, input logic [4*EW-1:0] a, b);
        int ae[4];
        int be[4];
        int v;
        logic [4*RW-1:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            ae[k] = int'(a[(3-k)*EW +: EW]);
            be[k] = int'(b[(3-k)*EW +: EW]);
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                case (op)
                    2'b00:   v = ae[2*i+j] + be[2*i+j];
                    2'b01:   v = ae[2*i+j] - be[2*i+j];
                    2'b10:   v = ae[2*i] * be[j] + ae[2*i+1] * be[2+j];
                    default: v = 0;
                endcase
                r[(3-(2*i+j))*RW +: RW] = RW'(v);
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one request, then follow it to its done pulse and compare
    // against the scoreboard entry pushed at issue time.
    task automatic run_op(input logic [1:0] op_i, input logic [4*EW-1:0] a_i, input logic [4*EW-1:0] b_i,
                          input logic [4*RW-1:0] c_e, input logic err_e, input int lat_e,
                          input bit toggle, input bit scramble, input string tag);
        exp_t e;
        int   k;
        int   busy_cnt;
        bit   seen;
        bit   stable;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        e.c = c_e; e.err = err_e; e.lat = lat_e;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        if (scramble) begin
            bus.a  = (4*EW)'($urandom);
            bus.b  = (4*EW)'($urandom);
            bus.op = 2'($urandom);
        end
        k = 1; busy_cnt = 0; seen = 1'b0; stable = 1'b1;
        while (!seen && k <= 40) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.c !== prev_c) stable = 1'b0;
                if (toggle) bus.start = ~bus.start;
                @(negedge clk);
                k++;
            end
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            chk({tag, "_timeout"}, 64'(k), 64'(e.lat));
        end else begin
            chk({tag, "_latency"}, 64'(k), 64'(e.lat));
            chk({tag, "_c"}, 64'(bus.c), 64'(e.c));
            chk({tag, "_err"}, 64'(bus.err), 64'(e.err));
            chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
            chk({tag, "_c_stable"}, 64'(stable), 64'd1);
        end
        @(negedge clk);
        chk({tag, "_done_single"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy_clear"}, 64'(bus.busy), 64'd0);
        prev_c = e.c;
    endtask

    initial begin
        int   k;
        bit   no_done;
        logic [1:0]      rop;
        logic [4*EW-1:0] ra;
        logic [4*EW-1:0] rb;

        checks = 0; passed = 0; prev_c = '0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;

        vt[0] = '{2'b00, pa(3'd2,3'd3,3'd4,3'd5), pa(3'd1,3'd2,3'd3,3'd4), pc(7'd3,7'd5,7'd7,7'd9), 1'b0, 5};
        vt[1] = '{2'b01, pa(3'd2,3'd3,3'd4,3'd5), pa(3'd1,3'd2,3'd3,3'd4), pc(7'd1,7'd1,7'd1,7'd1), 1'b0, 5};
        vt[2] = '{2'b01, pa(3'd1,3'd0,3'd7,3'd0), pa(3'd3,3'd0,3'd0,3'd7), pc(7'h7E,7'h00,7'h07,7'h79), 1'b0, 5};
        vt[3] = '{2'b10, pa(3'd2,3'd3,3'd4,3'd5), pa(3'd1,3'd2,3'd3,3'd4), pc(7'd11,7'd16,7'd19,7'd28), 1'b0, 9};
        vt[4] = '{2'b10, pa(3'd7,3'd7,3'd7,3'd7), pa(3'd7,3'd7,3'd7,3'd7), pc(7'd98,7'd98,7'd98,7'd98), 1'b0, 9};
        vt[5] = '{2'b11, pa(3'd2,3'd3,3'd4,3'd5), pa(3'd1,3'd2,3'd3,3'd4), pc(7'd0,7'd0,7'd0,7'd0), 1'b1, 1};
        vt[6] = '{2'b00, pa(3'd7,3'd7,3'd7,3'd7), pa(3'd7,3'd7,3'd7,3'd7), pc(7'd14,7'd14,7'd14,7'd14), 1'b0, 5};
        vt[7] = '{2'b01, pa(3'd0,3'd0,3'd0,3'd0), pa(3'd7,3'd7,3'd7,3'd7), pc(7'h79,7'h79,7'h79,7'h79), 1'b0, 5};

        // Reset state
        #12;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_err",  64'(bus.err),  64'd0);
        chk("reset_c",    64'(bus.c),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].err, vt[i].lat, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        // Random legal operations against the matrix model
        for (int i = 0; i < 4; i++) begin
            rop = 2'($urandom_range(0, 2));
            ra  = (4*EW)'($urandom);
            rb  = (4*EW)'($urandom);
            run_op(rop, ra, rb, model(rop, ra, rb), 1'b0, (rop == 2'b10) ? 9 : 5, 1'b0, 1'b0, $sformatf("rnd%0d", i));
        end

        // start toggled throughout a multiply: single done, result unaffected
        run_op(2'b10, pa(3'd2,3'd3,3'd4,3'd5), pa(3'd1,3'd2,3'd3,3'd4), pc(7'd11,7'd16,7'd19,7'd28), 1'b0, 9, 1'b1, 1'b0, "toggle");

        // Reset at edge T+4 of a multiply
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10;
        bus.a = pa(3'd7,3'd7,3'd7,3'd7); bus.b = pa(3'd7,3'd7,3'd7,3'd7);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_err",  64'(bus.err),  64'd0);
        chk("abort_c",    64'(bus.c),    64'd0);
        prev_c = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        no_done = 1'b1;
        for (k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) no_done = 1'b0;
        end
        chk("abort_no_done", 64'(no_done), 64'd1);
        run_op(2'b00, pa(3'd2,3'd3,3'd4,3'd5), pa(3'd1,3'd2,3'd3,3'd4), pc(7'd3,7'd5,7'd7,7'd9), 1'b0, 5, 1'b0, 1'b0, "post_reset_add");

        // Back-to-back with inputs scrambled right after accept
        run_op(2'b00, pa(3'd7,3'd1,3'd6,3'd2), pa(3'd5,3'd0,3'd3,3'd4), pc(7'd12,7'd1,7'd9,7'd6), 1'b0, 5, 1'b0, 1'b1, "b2b_add");
        run_op(2'b10, pa(3'd7,3'd1,3'd6,3'd2), pa(3'd5,3'd0,3'd3,3'd4), pc(7'd38,7'd4,7'd36,7'd8), 1'b0, 9, 1'b0, 1'b1, "b2b_mul");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
